// File: rtl/sdrc_req_arb_if.sv
// sdrc_req_arb_if: request bus between NPORT application masters, the arbiter and the SDRAM controller
//   p_req/p_addr/p_len/p_wr_n/p_wrap : per-port request fields (port i at [i*W +: W])
//   p_ack                            : per-port accept pulse back to the requesters
//   sd_req/sd_req_*                  : registered request towards the controller
//   sd_req_ack                       : controller accepted the request
//   arb_busy                         : arbiter is holding a granted request
//   modport master : arbiter side, slave : requesters + controller side
interface sdrc_req_arb_if #(
    parameter int NPORT  = 4,
    parameter int APP_AW = 25,
    parameter int APP_RW = 9,
    parameter int ID_W   = 4
);
    logic [NPORT-1:0]        p_req;
    logic [NPORT*APP_AW-1:0] p_addr;
    logic [NPORT*APP_RW-1:0] p_len;
    logic [NPORT-1:0]        p_wr_n;
    logic [NPORT-1:0]        p_wrap;
    logic [NPORT-1:0]        p_ack;
    logic                    sd_req;
    logic [ID_W-1:0]         sd_req_id;
    logic [APP_AW-1:0]       sd_req_addr;
    logic [APP_RW-1:0]       sd_req_len;
    logic                    sd_req_wr_n;
    logic                    sd_req_wrap;
    logic                    sd_req_ack;
    logic                    arb_busy;

    modport master (
        input  p_req, p_addr, p_len, p_wr_n, p_wrap, sd_req_ack,
        output p_ack, sd_req, sd_req_id, sd_req_addr, sd_req_len, sd_req_wr_n, sd_req_wrap, arb_busy
    );
    modport slave (
        output p_req, p_addr, p_len, p_wr_n, p_wrap, sd_req_ack,
        input  p_ack, sd_req, sd_req_id, sd_req_addr, sd_req_len, sd_req_wr_n, sd_req_wrap, arb_busy
    );
endinterface

// File: rtl/sdrc_req_arb.sv
// sdrc_req_arb: round-robin arbiter sharing the SDRAM controller request port between NPORT requesters
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : sdrc_req_arb_if.master (per-port requests in, registered sd_req_* out, p_ack back)
//   Optional macro SDRC_ARB_P0_PRIO_EN: port 0 gets strict priority, ports 1..NPORT-1 round-robin.
module sdrc_req_arb #(
    parameter int NPORT  = 4,
    parameter int APP_AW = 25,
    parameter int APP_RW = 9,
    parameter int ID_W   = 4
) (
    input  logic clk,
    input  logic reset,
    sdrc_req_arb_if.master bus
);
    localparam int PW = (NPORT > 2) ? 2 : 1;

    typedef enum logic [1:0] {ARB = 2'b00, HOLD = 2'b01} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     last_q;
    logic [ID_W-1:0]   id_q;
    logic              req_q, wr_n_q, wrap_q;
    logic [APP_AW-1:0] addr_q;
    logic [APP_RW-1:0] len_q;
    logic              any, found;
    int                sel, idx;
    logic [PW-1:0]     gnt;

    assign gnt = id_q[PW-1:0];
    assign any = |bus.p_req;

    // First requesting port after last_q; with priority, port 0 pre-empts and the
    // rotation only covers ports 1..NPORT-1.
    always_comb begin
        sel   = 0;
        found = 1'b0;
        idx   = 0;
`ifdef SDRC_ARB_P0_PRIO_EN
        if (bus.p_req[0]) begin
            found = 1'b1;
        end
        for (int k = 1; k < NPORT; k++) begin
            idx = ((int'(last_q) - 1 + k) % (NPORT - 1)) + 1;
            if (!found && bus.p_req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
`else
        for (int k = 1; k <= NPORT; k++) begin
            idx = (int'(last_q) + k) % NPORT;
            if (!found && bus.p_req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        state_d = (state_q == ARB) ? (any ? HOLD : ARB) : (bus.sd_req_ack ? ARB : HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            last_q  <= PW'(NPORT - 1);
            id_q    <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            wr_n_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB && any) begin
                req_q  <= 1'b1;
                id_q   <= ID_W'(sel);
                addr_q <= bus.p_addr[sel*APP_AW +: APP_AW];
                len_q  <= bus.p_len[sel*APP_RW +: APP_RW];
                wr_n_q <= bus.p_wr_n[sel];
                wrap_q <= bus.p_wrap[sel];
            end
            if (state_q == HOLD && bus.sd_req_ack) begin
                req_q <= 1'b0;
`ifdef SDRC_ARB_P0_PRIO_EN
                if (gnt != '0) last_q <= gnt;
`else
                last_q <= gnt;
`endif
            end
        end
    end

    assign bus.p_ack       = (state_q == HOLD && bus.sd_req_ack) ? (NPORT'(1) << gnt) : '0;
    assign bus.sd_req      = req_q;
    assign bus.sd_req_id   = id_q;
    assign bus.sd_req_addr = addr_q;
    assign bus.sd_req_len  = len_q;
    assign bus.sd_req_wr_n = wr_n_q;
    assign bus.sd_req_wrap = wrap_q;
    assign bus.arb_busy    = (state_q == HOLD);
endmodule

// File: tb/tb_sdrc_req_arb.sv
// tb_sdrc_req_arb: directed self-checking bench for sdrc_req_arb
module tb_sdrc_req_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sdrc_req_arb_if #(.NPORT(4), .APP_AW(25), .APP_RW(9), .ID_W(4)) bus ();

    sdrc_req_arb #(.NPORT(4), .APP_AW(25), .APP_RW(9), .ID_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [24:0] a, input logic [8:0] l, input logic w);
        bus.p_addr[p*25 +: 25] = a;
        bus.p_len[p*9 +: 9]    = l;
        bus.p_wr_n[p]          = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Arbitration edge, hold for `hold` cycles, ack, then check the bubble.
    task automatic do_grant(input string tag, input int id, input logic [24:0] a, input int hold);
        tick();
        chk({tag, "_req"}, 32'(bus.sd_req), 32'd1);
        chk({tag, "_id"}, 32'(bus.sd_req_id), 32'(id));
        chk({tag, "_addr"}, 32'(bus.sd_req_addr), 32'(a));
        for (int i = 0; i < hold; i++) tick();
        chk({tag, "_hold"}, 32'(bus.sd_req), 32'd1);
        bus.sd_req_ack = 1'b1;
        #1;
        chk({tag, "_pack"}, 32'(bus.p_ack), 32'(4'b1 << id));
        tick();
        bus.sd_req_ack = 1'b0;
        chk({tag, "_bubble"}, 32'(bus.sd_req), 32'd0);
        chk({tag, "_pack_off"}, 32'(bus.p_ack), 32'd0);
    endtask

    initial begin
        int exp_ord[6];
        bus.p_req = '0;
        bus.p_addr = '0;
        bus.p_len = '0;
        bus.p_wr_n = '1;
        bus.p_wrap = '0;
        bus.sd_req_ack = 1'b0;
        tick();
        do_reset();
        chk("rst_req", 32'(bus.sd_req), 32'd0);
        chk("rst_id", 32'(bus.sd_req_id), 32'd0);
        chk("rst_busy", 32'(bus.arb_busy), 32'd0);
        chk("rst_pack", 32'(bus.p_ack), 32'd0);
        // 1: single write request from port 0, ack after 3 cycles
        set_port(0, 25'h0000100, 9'd8, 1'b0);
        bus.p_req = 4'b0001;
        tick();
        chk("t1_req", 32'(bus.sd_req), 32'd1);
        chk("t1_id", 32'(bus.sd_req_id), 32'd0);
        chk("t1_addr", 32'(bus.sd_req_addr), 32'h100);
        chk("t1_len", 32'(bus.sd_req_len), 32'd8);
        chk("t1_wrn", 32'(bus.sd_req_wr_n), 32'd0);
        chk("t1_busy", 32'(bus.arb_busy), 32'd1);
        tick();
        tick();
        chk("t1_hold", 32'(bus.sd_req), 32'd1);
        bus.sd_req_ack = 1'b1;
        #1;
        chk("t1_pack", 32'(bus.p_ack), 32'b0001);
        tick();
        bus.sd_req_ack = 1'b0;
        bus.p_req = '0;
        chk("t1_drop", 32'(bus.sd_req), 32'd0);
        chk("t1_pack_off", 32'(bus.p_ack), 32'd0);
        chk("t1_idle", 32'(bus.arb_busy), 32'd0);
        // 2: all four requesting continuously
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 25'(32'h1000 * (p + 1)), 9'(p), 1'b1);
`ifdef SDRC_ARB_P0_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0, 1};
`endif
        bus.p_req = 4'b1111;
        for (int g = 0; g < 6; g++)
            do_grant($sformatf("t2_g%0d", g), exp_ord[g], 25'(32'h1000 * (exp_ord[g] + 1)), 1);
        bus.p_req = '0;
        // 3: port 2 changes fields and drops p_req during HOLD
        do_reset();
        set_port(2, 25'h0000ABC, 9'd4, 1'b1);
        bus.p_req = 4'b0100;
        tick();
        chk("t3_id", 32'(bus.sd_req_id), 32'd2);
        chk("t3_addr", 32'(bus.sd_req_addr), 32'hABC);
        set_port(2, 25'h1234567, 9'd1, 1'b0);
        bus.p_req = '0;
        tick();
        chk("t3_req_kept", 32'(bus.sd_req), 32'd1);
        chk("t3_addr_kept", 32'(bus.sd_req_addr), 32'hABC);
        chk("t3_len_kept", 32'(bus.sd_req_len), 32'd4);
        bus.sd_req_ack = 1'b1;
        #1;
        chk("t3_pack", 32'(bus.p_ack), 32'b0100);
        tick();
        bus.sd_req_ack = 1'b0;
        chk("t3_drop", 32'(bus.sd_req), 32'd0);
        // 4: stray ack while idle, then reset during HOLD
        bus.sd_req_ack = 1'b1;
        #1;
        chk("t4_stray_pack", 32'(bus.p_ack), 32'd0);
        tick();
        bus.sd_req_ack = 1'b0;
        chk("t4_stray_req", 32'(bus.sd_req), 32'd0);
        chk("t4_stray_busy", 32'(bus.arb_busy), 32'd0);
        set_port(3, 25'h0000333, 9'd3, 1'b1);
        bus.p_req = 4'b1000;
        tick();
        chk("t4_id3", 32'(bus.sd_req_id), 32'd3);
        chk("t4_busy", 32'(bus.arb_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_rst_req", 32'(bus.sd_req), 32'd0);
        chk("t4_rst_busy", 32'(bus.arb_busy), 32'd0);
        chk("t4_rst_pack", 32'(bus.p_ack), 32'd0);
        set_port(0, 25'h0000010, 9'd0, 1'b0);
        bus.p_req = 4'b1001;
        do_grant("t4_after_rst", 0, 25'h10, 0);
        bus.p_req = '0;
        // 5: last_gnt = 1, then ports 1 and 3 request
        set_port(1, 25'h0000111, 9'd1, 1'b0);
        bus.p_req = 4'b0010;
        do_grant("t5_pre", 1, 25'h111, 0);
        bus.p_req = 4'b1010;
        do_grant("t5_g3", 3, 25'h333, 0);
        do_grant("t5_g1", 1, 25'h111, 0);
        bus.p_req = '0;
`ifdef SDRC_ARB_P0_PRIO_EN
        // 6: port 0 strict priority, then 1 and 2 alternate
        do_reset();
        set_port(2, 25'h0000222, 9'd2, 1'b1);
        bus.p_req = 4'b0111;
        for (int g = 0; g < 3; g++) do_grant($sformatf("t6_p0_%0d", g), 0, 25'h10, 0);
        bus.p_req = 4'b0110;
        do_grant("t6_a", 1, 25'h111, 0);
        do_grant("t6_b", 2, 25'h222, 0);
        do_grant("t6_c", 1, 25'h111, 0);
        bus.p_req = '0;
`endif
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
